// File: rtl/serial_sub8.sv
// Bit-serial two's-complement subtractor, d = a - b, one bit per clock LSB first.
// A single full-adder slice computes a + ~b + 1 with a registered carry.
module serial_sub8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, d_sr_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    count_reg;
  logic             carry_reg, bout_reg, ovf_reg;
  logic             a_msb_reg, b_msb_reg;

  logic             sum_bit, carry_next, last_bit;
  logic [WIDTH-1:0] diff_full;

  // Full-adder slice fed with the inverted subtrahend bit.
  always_comb begin
    sum_bit    = a_sr_reg[0] ^ ~b_sr_reg[0] ^ carry_reg;
    carry_next = (a_sr_reg[0] & ~b_sr_reg[0]) |
                 (a_sr_reg[0] & carry_reg) |
                 (~b_sr_reg[0] & carry_reg);
    diff_full  = {sum_bit, d_sr_reg[WIDTH-1:1]};
    last_bit   = (count_reg == CW'(WIDTH - 1));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sr_reg  <= '0;
      b_sr_reg  <= '0;
      d_sr_reg  <= '0;
      d_reg     <= '0;
      count_reg <= '0;
      carry_reg <= 1'b0;
      bout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b;
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            d_sr_reg  <= '0;
            carry_reg <= 1'b1;
            count_reg <= '0;
          end
        end
        BUSY: begin
          a_sr_reg  <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg  <= {1'b0, b_sr_reg[WIDTH-1:1]};
          d_sr_reg  <= diff_full;
          carry_reg <= carry_next;
          if (last_bit) begin
            // Final bit: publish result; sum_bit is the result MSB.
            count_reg <= '0;
            d_reg     <= diff_full;
            bout_reg  <= ~carry_next;
            ovf_reg   <= (a_msb_reg != b_msb_reg) && (sum_bit != a_msb_reg);
          end else begin
            count_reg <= count_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign d         = d_reg;
  assign bout      = bout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed and randomized checks of serial_sub8: results, handshake, latency, stall and reset.
module tb_serial_sub8;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             ovf;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_sub8 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One complete operation: accept, latency, result, stall, retire.
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                        input logic eb, input logic eo, input int idle_gap, input int stall);
    int lat;
    bit found;
    in_valid = 1'b0;
    for (int i = 0; i < idle_gap; i++) tick();
    check("in_ready_idle", 32'(in_ready), 32'd1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b1;
    a = ~av;
    b = 8'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    found = 1'b0;
    for (int i = 1; i <= WIDTH + 4 && !found; i++) begin
      tick();
      if (out_valid) begin
        found = 1'b1;
        lat = i;
      end
    end
    check("latency", 32'(lat), 32'(WIDTH));
    check("d", 32'(d), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
    check("ovf", 32'(ovf), 32'(eo));
    out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_d", 32'({d, bout, ovf}), 32'({ed, eb, eo}));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("retire_valid", 32'(out_valid), 32'd0);
    check("retire_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    $display("op a=%02h b=%02h -> d=%02h bout=%0b ovf=%0b latency=%0d", av, bv, d, bout, ovf, lat);
  endtask

  initial begin
    logic [7:0] ra, rb, rd;
    logic       rbo, rov;
    int         sdiff;
    bit         seen;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b0;
    tick();

    run_op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 0, 1);
    run_op(8'd5, 8'd10, 8'hFB, 1'b1, 1'b0, 1, 0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 2);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 2, 0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0, 10);
    run_op(8'd9, 8'd3, 8'd6, 1'b0, 1'b0, 0, 0);

    // Abort an op in flight with reset on its third BUSY cycle.
    a = 8'd100;
    b = 8'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_flags", 32'({bout, ovf}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    $display("abort a=64 b=01 -> d=%02h out_valid_seen=%0b", d, seen);

    for (int n = 0; n < 300; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rd = ra - rb;
      rbo = (int'(ra) < int'(rb));
      sdiff = int'($signed(ra)) - int'($signed(rb));
      rov = (sdiff > 127) || (sdiff < -128);
      run_op(ra, rb, rd, rbo, rov, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
